// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO and its storage array.
// Benches use FIFO_DEPTH to size fill and wrap sequences.
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read with enable.
// Only the read register is reset; the storage contents are don't-care after reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register holds its value whenever no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/fifo.sv
// Single-clock FIFO with wrap-bit pointers, combinational full/empty flags and
// registered read data (no first-word fall-through).
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_accept;
    logic             w_rd_accept;

    // Equal low bits with differing wrap bits means the writer is a full lap ahead.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                     (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

    assign w_wr_accept = wr_en & ~w_full;
    assign w_rd_accept = rd_en & ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data (data_in),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data (data_out)
    );

    assign full  = w_full;
    assign empty = w_empty;
endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: stimulus queues the expected post-edge outputs,
// a monitor pops one entry per clock edge and compares.
module tb_fifo;
    import fifo_pkg::*;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    typedef struct {
        logic [7:0] data;
        logic       emp;
        logic       ful;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   step_id;

    fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %02h expected %02h", nm, id, act, exp);
        end
    endtask

    // One clock of stimulus; expected outputs describe the state after the next edge.
    task automatic cyc(input logic wr, input logic rd, input logic [7:0] din,
                       input logic [7:0] exp_d, input logic exp_e, input logic exp_f);
        exp_t e;
        @(negedge clk);
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
        step_id++;
        e.data = exp_d;
        e.emp  = exp_e;
        e.ful  = exp_f;
        e.id   = step_id;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data_out", e.id, data_out, e.data);
                check("empty", e.id, {7'd0, empty}, {7'd0, e.emp});
                check("full", e.id, {7'd0, full}, {7'd0, e.ful});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        step_id = 0;
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
        #1 rst = 1'b1;
        #1;
        check("rst_empty", 0, {7'd0, empty}, 8'd1);
        check("rst_full", 0, {7'd0, full}, 8'd0);
        check("rst_data", 0, data_out, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single write then read; data_out holds through idle cycles.
        cyc(1, 0, 8'hA5, 8'h00, 0, 0);
        cyc(0, 1, 8'h00, 8'hA5, 1, 0);
        cyc(0, 0, 8'h00, 8'hA5, 1, 0);
        cyc(0, 0, 8'h00, 8'hA5, 1, 0);
        // Underflow is ignored.
        cyc(0, 1, 8'h00, 8'hA5, 1, 0);

        // Fill to full, drop the 17th write, drain in order.
        for (int i = 0; i < FIFO_DEPTH; i++)
            cyc(1, 0, 8'(i), 8'hA5, 0, (i == FIFO_DEPTH - 1));
        cyc(1, 0, 8'hFF, 8'hA5, 0, 1);
        for (int i = 0; i < FIFO_DEPTH; i++)
            cyc(0, 1, 8'h00, 8'(i), (i == FIFO_DEPTH - 1), 0);
        cyc(0, 1, 8'h00, 8'h0F, 1, 0);

        // Full with both asserted: read only, oldest word out.
        for (int i = 0; i < FIFO_DEPTH; i++)
            cyc(1, 0, 8'(8'h40 + i), 8'h0F, 0, (i == FIFO_DEPTH - 1));
        cyc(1, 1, 8'hEE, 8'h40, 0, 0);
        for (int i = 1; i < FIFO_DEPTH; i++)
            cyc(0, 1, 8'h00, 8'(8'h40 + i), (i == FIFO_DEPTH - 1), 0);

        // Empty with both asserted: write only.
        cyc(1, 1, 8'h3C, 8'h4F, 0, 0);
        // Half full with both asserted: occupancy held, order kept.
        for (int i = 0; i < 7; i++)
            cyc(1, 0, 8'(8'h50 + i), 8'h4F, 0, 0);
        cyc(1, 1, 8'h57, 8'h3C, 0, 0);
        cyc(1, 1, 8'h58, 8'h50, 0, 0);
        cyc(1, 1, 8'h59, 8'h51, 0, 0);
        cyc(1, 1, 8'h5A, 8'h52, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 8'h00, 8'(8'h53 + i), (i == 7), 0);

        // Wrap-around: 10 then 12 words through the pointers.
        for (int i = 0; i < 10; i++)
            cyc(1, 0, 8'(8'h80 + i), 8'h5A, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc(0, 1, 8'h00, 8'(8'h80 + i), (i == 9), 0);
        for (int i = 0; i < 12; i++)
            cyc(1, 0, 8'(8'hC0 + i), 8'h89, 0, 0);
        for (int i = 0; i < 12; i++)
            cyc(0, 1, 8'h00, 8'(8'hC0 + i), (i == 11), 0);

        // Asynchronous reset mid-operation discards stored words.
        cyc(1, 0, 8'h11, 8'hCB, 0, 0);
        cyc(1, 0, 8'h22, 8'hCB, 0, 0);
        cyc(0, 1, 8'h00, 8'h11, 0, 0);
        cyc(0, 0, 8'h00, 8'h11, 0, 0);
        drain();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_empty", 0, {7'd0, empty}, 8'd1);
        check("async_rst_full", 0, {7'd0, full}, 8'd0);
        check("async_rst_data", 0, data_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 1, 8'h00, 8'h00, 1, 0);
        cyc(1, 0, 8'h77, 8'h00, 0, 0);
        cyc(0, 1, 8'h00, 8'h77, 1, 0);
        cyc(0, 0, 8'h00, 8'h77, 1, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock synchronous first-in/first-out buffer.
- Depth is 2**ADDR_WIDTH entries of DATA_WIDTH bits.
- Provides full/empty status and a registered read-data output.
- Used as a general rate/latency decoupling buffer between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH (16 by default).

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request; sampled at rising clk.
- rd_en  input  1  read request; sampled at rising clk.
- data_in  input  DATA_WIDTH  write data, captured when a write is accepted.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when the FIFO holds 2**ADDR_WIDTH words.
- empty  output  1  high when the FIFO holds 0 words.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (rst=1, takes effect immediately, independent of clk):
  - write pointer = 0, read pointer = 0.
  - data_out = 0, empty = 1, full = 0.
  - Memory contents are not cleared (don't-care).
  - Reset asserted mid-operation discards all stored words.
- Pointers:
  - Write and read pointers are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index memory.
  - The MSB is a wrap bit; pointers increment modulo 2**(ADDR_WIDTH+1).
- Status flags (combinational from registered pointers, no extra latency):
  - empty = (wr_ptr == rd_ptr).
  - full = low ADDR_WIDTH bits equal and MSBs differ.
  - Flags reflect the new state in the same cycle as the edge that changed the pointers.
- Write accept:
  - wr_accept = wr_en & ~full (flag value before the edge).
  - On accept: mem[wr_ptr] <= data_in; wr_ptr increments.
  - Write while full is silently dropped; no state change.
- Read accept:
  - rd_accept = rd_en & ~empty (flag value before the edge).
  - On accept: data_out <= mem[rd_ptr]; rd_ptr increments.
  - Read latency: data is valid on data_out right after the accepting edge, i.e. one cycle after rd_en is sampled.
  - Read while empty is ignored; data_out holds its previous value.
  - data_out holds its value whenever no read is accepted.
- Simultaneous wr_en and rd_en:
  - Each is qualified independently against the pre-edge flags.
  - Not empty and not full: both accepted; occupancy unchanged.
  - Empty: write accepted, read ignored; empty deasserts after the edge.
  - Full: read accepted, write dropped; full deasserts after the edge.
- No first-word fall-through: a written word appears on data_out only after a read accepts it.
- Ordering: words are returned strictly in write order, including across pointer wrap-around.
- No overflow/underflow error outputs; dropped operations are silent.

Decomposition:
- Shared package fifo_pkg:
  - Default constants FIFO_DATA_WIDTH=8 and FIFO_ADDR_WIDTH=4.
  - Derived depth constant for benches.
- One natural sub-module, fifo_mem: simple dual-port register array.
  - Synchronous write port; registered read port with enable.
  - Instantiated by fifo; pointer, flag and accept logic stay in fifo.

Test Plan:
- Reset: hold rst=1 with wr_en=rd_en=0 -> empty=1, full=0, data_out=8'h00.
  - Assert rst between clock edges -> outputs change immediately without waiting for clk.
- Single write/read: release rst, one-cycle wr_en=1 with data_in=8'hA5 -> empty=0 after that edge.
  - Then one-cycle rd_en=1 -> data_out=8'hA5 after the read edge and empty=1.
  - data_out stays 8'hA5 through subsequent idle cycles.
- Fill to full: write 16 words 8'h00..8'h0F -> full=1 after the 16th write.
  - 17th write with data 8'hFF is dropped.
  - Then 16 reads return 8'h00..8'h0F in order, and empty=1 after the last read.
- Underflow: rd_en=1 while empty -> data_out unchanged, pointers unchanged, empty stays 1.
- Simultaneous ops:
  - Empty + wr_en=rd_en=1 with data 8'h3C -> write only; count becomes 1.
  - Full + both asserted -> read only; full deasserts and the oldest word is output.
  - Half full + both asserted -> count unchanged and order preserved.
- Wrap-around: write 10 and read 10 words, then write 12 and read 12 with distinct values -> all read in order; full and empty are never falsely asserted.
